// File: rtl/ibpl_out_shaper.sv
// ibpl_out_shaper
// ---------------------------------------------------------------------------
// Per-channel output pulse shaper with an activity LED stretcher and a sticky
// lost-trigger (overrun) flag per channel.
//
// Each channel has two modes, selected by its width register W[i]:
//   W[i] == 0 : level mode. shaped_out follows trig_in & output_enable with
//               one cycle of latency.
//   W[i] >  0 : pulse mode. A rising edge of trig_in starts a pulse of exactly
//               W[i] cycles. The pulse is followed by HOLDOFF low cycles. A
//               trigger during the pulse either reloads the pulse (retrigger
//               mask bit set) or is lost. A trigger during holdoff is always
//               lost. Lost triggers set overrun[i].
//
// Configuration register map (cfg_we strobe, one write per cycle):
//   addr 0..5 : width of channel 0..5 (cfg_wdata)
//   addr 6    : retrigger mask (cfg_wdata[NCH-1:0])
//   addr 7    : overrun write-1-to-clear (cfg_wdata[NCH-1:0])
//
// Handshake: there is no flow control. cfg_we qualifies cfg_addr/cfg_wdata in
// the cycle it is high, and every write is accepted at the next rising edge.
//
// Ports
//   clk            system clock, rising edge
//   nReset         asynchronous active-low reset
//   trig_in        per-channel trigger request
//   output_enable  per-channel enable; low forces the channel off
//   cfg_we         configuration write strobe
//   cfg_addr       register select
//   cfg_wdata      write data
//   shaped_out     shaped channel outputs
//   output_act     stretched activity indication per channel
//   overrun        sticky per-channel lost-trigger flag
//   shaper_error   OR of all overrun bits, registered
//   fsm_state      debug view of every channel FSM, 2 bits per channel
//                  (0 = IDLE, 1 = ACTIVE, 2 = HOLD)
// ---------------------------------------------------------------------------
module ibpl_out_shaper #(
    parameter int NCH         = 6,
    parameter int CNT_W       = 16,
    parameter int HOLDOFF     = 4,
    parameter int LED_STRETCH = 1048576
) (
    input  logic               clk,
    input  logic               nReset,
    input  logic [NCH-1:0]     trig_in,
    input  logic [NCH-1:0]     output_enable,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_addr,
    input  logic [CNT_W-1:0]   cfg_wdata,
    output logic [NCH-1:0]     shaped_out,
    output logic [NCH-1:0]     output_act,
    output logic [NCH-1:0]     overrun,
    output logic               shaper_error,
    output logic [2*NCH-1:0]   fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [7:0]  HOLD_M1 = 8'(HOLDOFF - 1);
    localparam logic [23:0] LED_M1  = 24'(LED_STRETCH - 1);

    state_t           state    [NCH];
    logic [CNT_W-1:0] width    [NCH];
    logic [CNT_W-1:0] cnt      [NCH];
    logic [7:0]       hold_cnt [NCH];
    logic [23:0]      led_cnt  [NCH];

    logic [NCH-1:0]   trig_prev;
    logic [NCH-1:0]   armed;
    logic [NCH-1:0]   retrig_mask;
    logic [NCH-1:0]   shaped_prev;
    logic [NCH-1:0]   trig_edge;
    logic [NCH-1:0]   shaped_rise;
    logic [NCH-1:0]   ovr_set;
    logic [NCH-1:0]   ovr_clr;

    // trig_prev resets to all ones so that a trigger held high across reset
    // release is not seen as a fresh edge.
    assign trig_edge   = trig_in & ~trig_prev;
    assign shaped_rise = shaped_out & ~shaped_prev;

    always_comb begin
        ovr_set = '0;
        ovr_clr = '0;
        for (int i = 0; i < NCH; i++) begin
            if (trig_edge[i] && output_enable[i]) begin
                if ((state[i] == ST_ACTIVE && !retrig_mask[i]) || state[i] == ST_HOLD) begin
                    ovr_set[i] = 1'b1;
                end
            end
        end
        if (cfg_we && cfg_addr == 3'd7) begin
            ovr_clr = cfg_wdata[NCH-1:0];
        end
    end

    always_comb begin
        fsm_state = '0;
        for (int i = 0; i < NCH; i++) begin
            fsm_state[2*i +: 2] = state[i];
        end
    end

    // Edge tracking, level-mode arming, retrigger mask and overrun flags.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            trig_prev    <= '1;
            armed        <= '0;
            retrig_mask  <= '0;
            overrun      <= '0;
            shaper_error <= 1'b0;
        end else begin
            trig_prev <= trig_in;
            // Level mode only follows trig_in once it has been seen low after
            // reset, so a level held through reset produces no output.
            armed     <= armed | ~trig_in;
            if (cfg_we && cfg_addr == 3'd6) begin
                retrig_mask <= cfg_wdata[NCH-1:0];
            end
            // A set in the same cycle as a clear wins.
            overrun      <= (overrun & ~ovr_clr) | ovr_set;
            shaper_error <= |overrun;
        end
    end

    // Per-channel width registers and pulse FSMs.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < NCH; i++) begin
                state[i]    <= ST_IDLE;
                width[i]    <= '0;
                cnt[i]      <= '0;
                hold_cnt[i] <= '0;
            end
            shaped_out <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cfg_we && cfg_addr == 3'(i)) begin
                    width[i] <= cfg_wdata;
                end

                if (!output_enable[i]) begin
                    state[i]      <= ST_IDLE;
                    cnt[i]        <= '0;
                    hold_cnt[i]   <= '0;
                    shaped_out[i] <= 1'b0;
                end else begin
                    case (state[i])
                        ST_IDLE: begin
                            if (width[i] == '0) begin
                                shaped_out[i] <= trig_in[i] & armed[i];
                            end else if (trig_edge[i]) begin
                                // cnt holds the remaining high cycles after this one.
                                state[i]      <= ST_ACTIVE;
                                cnt[i]        <= width[i] - CNT_W'(1);
                                shaped_out[i] <= 1'b1;
                            end else begin
                                shaped_out[i] <= 1'b0;
                            end
                        end
                        ST_ACTIVE: begin
                            if (trig_edge[i] && retrig_mask[i]) begin
                                // Retrigger reloads from the current width;
                                // a width of zero just ends the pulse next cycle.
                                cnt[i] <= (width[i] == '0) ? '0 : width[i] - CNT_W'(1);
                            end else if (cnt[i] == '0) begin
                                state[i]      <= ST_HOLD;
                                hold_cnt[i]   <= HOLD_M1;
                                shaped_out[i] <= 1'b0;
                            end else begin
                                cnt[i] <= cnt[i] - CNT_W'(1);
                            end
                        end
                        ST_HOLD: begin
                            if (hold_cnt[i] == 8'd0) begin
                                state[i] <= ST_IDLE;
                            end else begin
                                hold_cnt[i] <= hold_cnt[i] - 8'd1;
                            end
                        end
                        default: begin
                            state[i]      <= ST_IDLE;
                            shaped_out[i] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // Activity LED stretcher: restarts on every rising edge of shaped_out.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            shaped_prev <= '0;
            output_act  <= '0;
            for (int i = 0; i < NCH; i++) begin
                led_cnt[i] <= '0;
            end
        end else begin
            shaped_prev <= shaped_out;
            for (int i = 0; i < NCH; i++) begin
                if (shaped_rise[i]) begin
                    output_act[i] <= 1'b1;
                    led_cnt[i]    <= LED_M1;
                end else if (output_act[i]) begin
                    if (led_cnt[i] == 24'd0) begin
                        output_act[i] <= 1'b0;
                    end else begin
                        led_cnt[i] <= led_cnt[i] - 24'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ibpl_out_shaper.sv
// Bench for ibpl_out_shaper. Each scenario pushes per-cycle stimulus and the
// expected {output_act, shaped_out} of one channel; the runner pops both
// every cycle, compares, then drives. Flag registers are checked directly.
module tb_ibpl_out_shaper;

    localparam int NCH = 6;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [NCH-1:0]   trig;
        logic [NCH-1:0]   oe;
        logic             we;
        logic [2:0]       addr;
        logic [CNT_W-1:0] wdata;
    } stim_t;

    logic               clk;
    logic               nReset;
    logic [NCH-1:0]     trig_in;
    logic [NCH-1:0]     output_enable;
    logic               cfg_we;
    logic [2:0]         cfg_addr;
    logic [CNT_W-1:0]   cfg_wdata;
    logic [NCH-1:0]     shaped_out;
    logic [NCH-1:0]     output_act;
    logic [NCH-1:0]     overrun;
    logic               shaper_error;
    logic [2*NCH-1:0]   fsm_state;

    stim_t      stim_q[$];
    logic [1:0] exp_q[$];
    int         n_vec;
    int         n_miss;

    ibpl_out_shaper #(
        .NCH(NCH), .CNT_W(CNT_W), .HOLDOFF(4), .LED_STRETCH(8)
    ) dut (
        .clk(clk), .nReset(nReset), .trig_in(trig_in),
        .output_enable(output_enable), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .shaped_out(shaped_out), .output_act(output_act),
        .overrun(overrun), .shaper_error(shaper_error), .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic cfg_write(input logic [2:0] a, input logic [CNT_W-1:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic push(input logic [NCH-1:0] trig, input logic [NCH-1:0] oe,
                        input logic we, input logic [2:0] addr, input logic [CNT_W-1:0] wdata,
                        input logic exp_sh, input logic exp_act);
        stim_t s;
        s.trig = trig; s.oe = oe; s.we = we; s.addr = addr; s.wdata = wdata;
        stim_q.push_back(s);
        exp_q.push_back({exp_act, exp_sh});
    endtask

    // scoreboard runner: compare the current cycle, then drive the next inputs
    task automatic run_queue(input string name, input int ch);
        stim_t      s;
        logic [1:0] e;
        int         k;
        k = 0;
        while (stim_q.size() > 0) begin
            @(negedge clk);
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            check($sformatf("%s k%0d shaped", name, k), 32'(shaped_out[ch]), 32'(e[0]));
            check($sformatf("%s k%0d act", name, k), 32'(output_act[ch]), 32'(e[1]));
            trig_in = s.trig; output_enable = s.oe;
            cfg_we = s.we; cfg_addr = s.addr; cfg_wdata = s.wdata;
            k++;
        end
        trig_in = '0;
        cfg_we  = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_miss = 0;
        nReset = 1'b0; trig_in = '0; output_enable = '1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;

        // reset state
        #12;
        check("rst shaped", 32'(shaped_out), 32'h0);
        check("rst act", 32'(output_act), 32'h0);
        check("rst ovr", 32'(overrun), 32'h0);
        check("rst err", 32'(shaper_error), 32'h0);
        check("rst fsm", 32'(fsm_state), 32'h0);
        repeat (2) @(negedge clk);
        nReset = 1'b1;

        // ch0 W=5: pulse, holdoff, trigger lost in holdoff, first idle accepted
        cfg_write(3'd0, 16'd5);
        for (int k = 0; k < 24; k++)
            push((k == 0 || k == 7 || k == 10) ? 6'b000001 : 6'b000000, '1, 1'b0, 3'd0, '0,
                 (k >= 1 && k <= 5) || (k >= 11 && k <= 15),
                 (k >= 2 && k <= 9) || (k >= 12 && k <= 19));
        run_queue("ch0pulse", 0);
        check("ch0 ovr", 32'(overrun), 32'h01);
        check("ch0 err", 32'(shaper_error), 32'h1);
        cfg_write(3'd7, 16'h0001);
        check("ch0 clr", 32'(overrun), 32'h0);

        // ch0 output_enable dropped mid-pulse; trigger while disabled ignored
        for (int k = 0; k < 23; k++)
            push((k == 0 || k == 5 || k == 9) ? 6'b000001 : 6'b000000,
                 (k >= 2 && k <= 7) ? 6'b111110 : 6'b111111, 1'b0, 3'd0, '0,
                 (k >= 1 && k <= 2) || (k >= 10 && k <= 14),
                 (k >= 2 && k <= 9) || (k >= 11 && k <= 18));
        run_queue("ch0oe", 0);
        check("ch0oe ovr", 32'(overrun), 32'h0);

        // ch1 W=10, no retrigger: second trigger lost; width write mid-pulse
        cfg_write(3'd1, 16'd10);
        for (int k = 0; k < 17; k++)
            push((k == 0 || k == 3) ? 6'b000010 : 6'b000000, '1,
                 k == 5, 3'd1, 16'd2,
                 k >= 1 && k <= 10, k >= 2 && k <= 9);
        run_queue("ch1lost", 1);
        check("ch1 ovr", 32'(overrun), 32'h02);
        check("ch1 err", 32'(shaper_error), 32'h1);
        cfg_write(3'd7, 16'h0002);
        check("ch1 clr", 32'(overrun), 32'h0);
        @(negedge clk);
        check("ch1 err clr", 32'(shaper_error), 32'h0);

        // ch1 W=2 now: lost trigger in holdoff coincides with clear; set wins
        for (int k = 0; k < 11; k++)
            push((k == 0 || k == 4) ? 6'b000010 : 6'b000000, '1,
                 k == 4, 3'd7, 16'h0002,
                 k >= 1 && k <= 2, k >= 2 && k <= 9);
        run_queue("ch1setwins", 1);
        check("ch1 setwins", 32'(overrun), 32'h02);
        cfg_write(3'd7, 16'h0002);

        // ch2 W=10 with retrigger: 14 high cycles, no overrun
        cfg_write(3'd2, 16'd10);
        cfg_write(3'd6, 16'h0004);
        for (int k = 0; k < 21; k++)
            push((k == 0 || k == 4) ? 6'b000100 : 6'b000000, '1, 1'b0, 3'd0, '0,
                 k >= 1 && k <= 14, k >= 2 && k <= 9);
        run_queue("ch2retrig", 2);
        check("ch2 ovr", 32'(overrun), 32'h0);

        // ch3 level mode; enable dropped partway through the second level
        for (int k = 0; k < 33; k++)
            push(((k >= 0 && k <= 6) || (k >= 20 && k <= 26)) ? 6'b001000 : 6'b000000,
                 (k >= 23 && k <= 27) ? 6'b110111 : 6'b111111, 1'b0, 3'd0, '0,
                 (k >= 1 && k <= 7) || (k >= 21 && k <= 23),
                 (k >= 2 && k <= 9) || (k >= 22 && k <= 29));
        run_queue("ch3level", 3);
        check("ch3 ovr", 32'(overrun), 32'h0);

        // ch5 level mode, edges 5 cycles apart: LED stretch restarts
        for (int k = 0; k < 29; k++)
            push((k % 5 == 0 && k <= 15) ? 6'b100000 : 6'b000000, '1, 1'b0, 3'd0, '0,
                 k == 1 || k == 6 || k == 11 || k == 16, k >= 2 && k <= 24);
        run_queue("ch5led", 5);

        // ch4 W=100, reset at pulse cycle 20
        cfg_write(3'd4, 16'd100);
        for (int k = 0; k < 21; k++)
            push(k == 0 ? 6'b010000 : 6'b000000, '1, 1'b0, 3'd0, '0,
                 k >= 1 && k <= 20, k >= 2 && k <= 9);
        run_queue("ch4pulse", 4);
        #2 nReset = 1'b0;
        #1;
        check("rst async shaped", 32'(shaped_out), 32'h0);
        check("rst async fsm", 32'(fsm_state), 32'h0);
        trig_in = 6'b010000;
        repeat (2) @(negedge clk);
        nReset = 1'b1;
        // trigger held across release gives nothing; later edge is level mode
        for (int k = 0; k < 19; k++)
            push((k <= 5 || k == 7) ? 6'b010000 : 6'b000000, '1, 1'b0, 3'd0, '0,
                 k == 8, k >= 9 && k <= 16);
        run_queue("ch4after", 4);
        check("ch4 ovr", 32'(overrun), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ibpl_out_shaper.md
IBPL_OUT_SHAPER -- requirements
Module: ibpl_out_shaper

Interface
REQ-001 Parameter NCH, default 6, number of output channels.
REQ-002 Parameter CNT_W, default 16, pulse width counter width in bits.
REQ-003 Parameter HOLDOFF, default 4, minimum low time in clk cycles after each pulse (range 1..255).
REQ-004 Parameter LED_STRETCH, default 1048576, activity LED on-time in clk cycles (range 1..2^24-1).
REQ-005 Port clk, in, 1, single system clock; all logic is synchronous to its rising edge.
REQ-006 Port nReset, in, 1, reset, asynchronous assertion, active-low.
REQ-007 Port trig_in, in, NCH, per-channel trigger request, synchronous to clk.
REQ-008 Port output_enable, in, NCH, per-channel enable; low forces the channel off.
REQ-009 Port cfg_we, in, 1, configuration write strobe, one cycle per write.
REQ-010 Port cfg_addr, in, 3, register select: 0..5 = width of channel 0..5; 6 = retrigger mask; 7 = overrun clear.
REQ-011 Port cfg_wdata, in, CNT_W, write data.
REQ-012 Port shaped_out, out, NCH, shaped channel outputs; feeds the output cardlet's internal_out[5:0].
REQ-013 Port output_act, out, NCH, stretched activity indication for the LED row.
REQ-014 Port overrun, out, NCH, sticky per-channel flag: a trigger was lost.
REQ-015 Port shaper_error, out, 1, OR-reduction of overrun.

Function
REQ-016 Each channel detects a trigger as a rising edge of trig_in, i.e. trig_in high now and low in the previous cycle.
REQ-017 Width register W[i] = 0 selects level mode: shaped_out[i] = trig_in[i] & output_enable[i], registered, with 1-cycle latency, and the FSM stays IDLE.
REQ-018 W[i] > 0 selects pulse mode, with per-channel FSM states IDLE, ACTIVE and HOLD.
REQ-019 IDLE -> ACTIVE on a trigger; shaped_out goes high the next cycle and stays high for exactly W[i] cycles.
REQ-020 ACTIVE -> HOLD when the counter expires; shaped_out is low for exactly HOLDOFF cycles; HOLD -> IDLE afterwards.
REQ-021 A trigger in ACTIVE with retrigger mask bit = 1 reloads the counter, so the pulse stays high W[i] cycles from that trigger; this is not an overrun.
REQ-022 A trigger in ACTIVE with mask bit = 0, or any trigger in HOLD, is dropped and sets overrun[i].
REQ-023 W[i] is sampled at the IDLE -> ACTIVE transition and at each retrigger; a write during ACTIVE does not alter the running pulse.
REQ-024 Writing the retrigger mask (addr 6) uses cfg_wdata[NCH-1:0] and takes effect the next cycle.
REQ-025 Writing addr 7 clears each overrun bit whose cfg_wdata bit is 1 (write-1-to-clear).
REQ-026 If a set event and a clear for the same bit occur in one cycle, the set wins.
REQ-027 output_enable[i] low forces shaped_out[i] to 0 the next cycle, returns the FSM to IDLE and cancels the counter.
REQ-028 Triggers while output_enable[i] is low are ignored and do not set overrun.
REQ-029 output_act[i] goes high the cycle after any rising edge of shaped_out[i] and stays high LED_STRETCH cycles.
REQ-030 A further rising edge of shaped_out[i] during the LED stretch restarts the stretch count.
REQ-031 Counters never wrap: the width counter saturates at 0 and the LED counter stops at 0.
REQ-032 All outputs are registered; shaper_error lags overrun by no more than 1 cycle.

Reset
REQ-033 While nReset is low: shaped_out, output_act and overrun are 0; shaper_error is 0; all FSMs are IDLE; all W[i] are 0; the retrigger mask is 0.
REQ-034 nReset asserted mid-pulse drops shaped_out asynchronously; the first trigger counted after release is a rising edge that occurs after release.

Verification
REQ-035 W[0]=5, single-cycle trig_in[0] at cycle n -> shaped_out[0] high cycles n+1..n+5, low n+6..n+9, output_act[0] high from n+2.
REQ-036 W[1]=10, mask=0, second trigger 3 cycles after the first -> pulse still 10 cycles, overrun[1]=1, shaper_error=1; write addr 7 data 0x02 -> overrun[1]=0.
REQ-037 W[2]=10, mask bit2=1, retrigger 4 cycles after the first -> shaped_out[2] high 14 cycles total, overrun[2]=0.
REQ-038 W[3]=0, trig_in[3] high 7 cycles -> shaped_out[3] high 7 cycles, delayed by 1 cycle; output_enable[3] dropped midway -> low the next cycle.
REQ-039 W[4]=100, nReset pulsed low at pulse cycle 20 -> shaped_out[4]=0 immediately; W[4]=0 after release; no output without a new edge.
REQ-040 LED_STRETCH=8, shaped_out[5] edges 5 cycles apart -> output_act[5] continuous, dropping 8 cycles after the last edge.
